// File: rtl/uart_serial_link.sv
//-----------------------------------------------------------------------------
// uart_serial_link
//
// Single-clock UART link: an 11-bit raw-frame transmitter and receiver.
// Each direction has its own bit-slot timing generator: a counter over
// 0..CLKS_PER_BIT-1 and a 4-bit slot index over 0..10.
//
// Frame layout on the wire, LSB first:
//   bit0 start, bits1-8 data, bit9 parity, bit10 stop.
// Frames pass through unchanged. Parity is not checked. The stop bit is
// reported through rx_frame_err.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit slot. Must be even and >= 4.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   tx_start      request to send tx_frame; taken only while tx_busy = 0
//   tx_frame      11-bit raw frame, sent bit0 first
//   tx_busy       high while a frame is being shifted out
//   txd           serial output, idles high
//   rxd           serial input, asynchronous to clk
//   rx_frame      last received frame, bit0 = first bit received
//   rx_valid      one-cycle pulse when rx_frame updates
//   rx_frame_err  ~stop bit of the last frame; held until the next frame
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_serial_link #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [10:0] tx_frame,
    output logic        tx_busy,
    output logic        txd,
    input  logic        rxd,
    output logic [10:0] rx_frame,
    output logic        rx_valid,
    output logic        rx_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]       SLOT_LAST = 4'd10;

    // Transmitter states
    localparam logic TX_IDLE = 1'b0;
    localparam logic TX_SEND = 1'b1;

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_BREAK = 2'd3;

    //-------------------------------------------------------------------------
    // Transmitter
    //-------------------------------------------------------------------------
    logic             tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_slot;
    // Bits still to be sent. The bit on the wire is txd itself, so only
    // frame[10:1] is kept here.
    logic [9:0]       tx_shreg;

    assign tx_busy = (tx_state == TX_SEND);

    // NOTE: every clocked block uses non-blocking assignments. Each register
    // then sees the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_slot  <= '0;
            tx_shreg <= '0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        // Latch the whole frame now, so later changes to
                        // tx_frame cannot affect this transmission.
                        txd      <= tx_frame[0];
                        tx_shreg <= tx_frame[10:1];
                        tx_cnt   <= '0;
                        tx_slot  <= '0;
                        tx_state <= TX_SEND;
                    end
                end

                TX_SEND: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_slot == SLOT_LAST) begin
                            txd      <= 1'b1;
                            tx_slot  <= '0;
                            tx_state <= TX_IDLE;
                        end else begin
                            txd      <= tx_shreg[0];
                            tx_shreg <= {1'b1, tx_shreg[9:1]};
                            tx_slot  <= tx_slot + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end

                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Receiver input synchronizer
    // Both flops reset to the idle level. Otherwise leaving reset would look
    // like a start bit.
    //-------------------------------------------------------------------------
    logic rxd_meta;
    logic rxd_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    //-------------------------------------------------------------------------
    // Receiver
    //-------------------------------------------------------------------------
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_slot;
    // Bits 0..9 collect here, shifting in at the top. After bit9 the start
    // bit sits at index 0, and bit10 is appended directly from rxd_s.
    logic [9:0]       rx_shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_slot      <= '0;
            rx_shreg     <= '0;
            rx_frame     <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            case (rx_state)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end

                // Wait half a slot, then sample the middle of the start bit.
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (rxd_s) begin
                            // The line went back high: treat it as a glitch.
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_shreg <= {1'b0, rx_shreg[9:1]};
                            rx_slot  <= 4'd1;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end

                // From here on, sample once per slot, in the middle of each bit.
                RX_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_slot == SLOT_LAST) begin
                            rx_frame     <= {rxd_s, rx_shreg};
                            rx_valid     <= 1'b1;
                            rx_frame_err <= ~rxd_s;
                            rx_slot      <= '0;
                            // A low stop bit means a framing error or a break.
                            // Wait for the line to go high before re-arming,
                            // so a held-low line yields only one frame.
                            rx_state     <= rxd_s ? RX_IDLE : RX_BREAK;
                        end else begin
                            rx_shreg <= {rxd_s, rx_shreg[9:1]};
                            rx_slot  <= rx_slot + 4'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end

                RX_BREAK: begin
                    if (rxd_s) begin
                        rx_state <= RX_IDLE;
                    end
                end

                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_serial_link.sv
//-----------------------------------------------------------------------------
// tb_uart_serial_link
//
// Directed bench for uart_serial_link.
// By default rxd is tied to txd (loopback). For the glitch test the bench
// drives rxd directly instead.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_serial_link;

    localparam int CPB       = 16;
    localparam int BUSY_LEN  = 11 * CPB;
    localparam int WAIT_MAX  = 15 * CPB;

    logic        clk;
    logic        rst_n;
    logic        tx_start;
    logic [10:0] tx_frame;
    logic        tx_busy;
    logic        txd;
    logic        rxd;
    logic [10:0] rx_frame;
    logic        rx_valid;
    logic        rx_frame_err;

    logic        loop_en;
    logic        rxd_drv;

    int checks   = 0;
    int failures = 0;

    // Captured receive events and TX busy time, sampled on the falling edge.
    int          vld_cnt     = 0;
    int          busy_cycles = 0;
    logic [10:0] frames [32];
    logic        errs   [32];

    assign rxd = loop_en ? txd : rxd_drv;

    uart_serial_link #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_start     (tx_start),
        .tx_frame     (tx_frame),
        .tx_busy      (tx_busy),
        .txd          (txd),
        .rxd          (rxd),
        .rx_frame     (rx_frame),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_busy) busy_cycles++;
        if (rx_valid) begin
            if (vld_cnt < 32) begin
                frames[vld_cnt] = rx_frame;
                errs[vld_cnt]   = rx_frame_err;
            end
            vld_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic send(input logic [10:0] f);
        @(negedge clk);
        tx_frame = f;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Waits until the receive count reaches target. If the wait runs out,
    // the comparison below reports a shortfall.
    task automatic wait_valid(input int target, input string tag);
        int n;
        n = 0;
        while (vld_cnt < target && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check(tag, vld_cnt, target);
    endtask

    task automatic wait_tx_idle(input string tag);
        int n;
        n = 0;
        while (tx_busy && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check(tag, tx_busy, 1'b0);
    endtask

    task automatic rx_bit(input logic b);
        rxd_drv = b;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_frame = '0;
        loop_en  = 1'b1;
        rxd_drv  = 1'b1;

        // ---- Reset values
        repeat (3) @(negedge clk);
        check("rst_txd",      txd,          1'b1);
        check("rst_busy",     tx_busy,      1'b0);
        check("rst_rx_frame", rx_frame,     11'h000);
        check("rst_rx_valid", rx_valid,     1'b0);
        check("rst_rx_err",   rx_frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ---- Loopback, good frame
        busy_cycles = 0;
        send(11'h54A);
        wait_valid(1, "good_valid_cnt");
        check("good_frame", frames[0], 11'h54A);
        check("good_err",   errs[0],   1'b0);
        wait_tx_idle("good_tx_done");
        check("good_busy_len", busy_cycles, BUSY_LEN);
        repeat (3 * CPB) @(negedge clk);
        check("good_single", vld_cnt, 1);

        // ---- Reset in the middle of a transmission
        send(11'h7FE);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_txd",      txd,          1'b1);
        check("midrst_busy",     tx_busy,      1'b0);
        check("midrst_rx_frame", rx_frame,     11'h000);
        check("midrst_rx_err",   rx_frame_err, 1'b0);
        check("midrst_rx_valid", rx_valid,     1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14 * CPB) @(negedge clk);
        check("midrst_no_valid", vld_cnt, 1);

        // ---- Loopback, stop bit low
        send(11'h024);
        wait_valid(2, "brk_valid_cnt");
        check("brk_frame", frames[1], 11'h024);
        check("brk_err",   errs[1],   1'b1);
        wait_tx_idle("brk_tx_done");
        repeat (4 * CPB) @(negedge clk);
        check("brk_single", vld_cnt, 2);

        // ---- Back-to-back frames
        send(11'h7FE);
        begin
            int n;
            n = 0;
            while (tx_busy && n < WAIT_MAX) begin
                @(negedge clk);
                n++;
            end
        end
        // tx_busy has just dropped. Request the next frame right away.
        tx_frame = 11'h400;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("b2b_accepted", tx_busy, 1'b1);
        wait_valid(4, "b2b_valid_cnt");
        check("b2b_frame0", frames[2], 11'h7FE);
        check("b2b_err0",   errs[2],   1'b0);
        check("b2b_frame1", frames[3], 11'h400);
        check("b2b_err1",   errs[3],   1'b0);
        wait_tx_idle("b2b_tx_done");
        repeat (2 * CPB) @(negedge clk);

        // ---- Glitch rejection, then a directly driven frame 0x6AA
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        rxd_drv = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_no_valid", vld_cnt, 4);
        begin
            logic [10:0] f;
            f = 11'h6AA;
            for (int i = 0; i < 11; i++) rx_bit(f[i]);
        end
        rxd_drv = 1'b1;
        wait_valid(5, "glitch_rx_valid_cnt");
        check("glitch_rx_frame", frames[4], 11'h6AA);
        check("glitch_rx_err",   errs[4],   1'b0);
        repeat (2 * CPB) @(negedge clk);
        loop_en = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // ---- tx_start while busy is ignored
        base = vld_cnt;
        busy_cycles = 0;
        send(11'h7FE);
        repeat (5 * CPB) @(negedge clk);
        tx_frame = 11'h000;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_valid(base + 1, "busyrej_valid_cnt");
        check("busyrej_frame", frames[base], 11'h7FE);
        check("busyrej_err",   errs[base],   1'b0);
        wait_tx_idle("busyrej_tx_done");
        check("busyrej_busy_len", busy_cycles, BUSY_LEN);
        repeat (14 * CPB) @(negedge clk);
        check("busyrej_no_extra", vld_cnt, base + 1);
        check("busyrej_idle_txd", txd, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
